traffic_density_sensor: RTL and testbench

Producer side of the 2-bit per-approach traffic-density interface consumed by the adaptive signal controller. Four raw loop-detector inputs (north, south, east, west) are synchronised, debounced and converted to vehicle-arrival events. Arrivals are counted over a fixed sampling window, and each window's count is classified into a registered density code `sensor_*` (00 none, 01 low, 10 medium, 11 high). The codes feed the controller's green-time selection directly.

---
 rtl/traffic_pkg.sv | 33 +++
 rtl/det_channel.sv | 69 ++++++
 rtl/traffic_density_sensor.sv | 131 +++++++++++++
 tb/tb_traffic_density_sensor.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// ---------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the traffic-density interface between the sensor
// block and the adaptive signal controller.
//   DENS_NONE / DENS_LOW / DENS_MED / DENS_HIGH : 2-bit density codes
//   classify_density()                          : window count -> density code
// ---------------------------------------------------------------------------
package traffic_pkg;

    localparam logic [1:0] DENS_NONE = 2'b00;
    localparam logic [1:0] DENS_LOW  = 2'b01;
    localparam logic [1:0] DENS_MED  = 2'b10;
    localparam logic [1:0] DENS_HIGH = 2'b11;

    // Thresholds are tested lowest first, so a count is placed in the
    // highest band whose threshold it reaches.
    function automatic logic [1:0] classify_density(
        input int unsigned count,
        input int unsigned th_low,
        input int unsigned th_med,
        input int unsigned th_high
    );
        if (count < th_low) begin
            return DENS_NONE;
        end else if (count < th_med) begin
            return DENS_LOW;
        end else if (count < th_high) begin
            return DENS_MED;
        end
        return DENS_HIGH;
    endfunction

endpackage

// File: rtl/det_channel.sv
// ---------------------------------------------------------------------------
// det_channel
// One loop-detector channel: two-flop synchroniser, debounce filter and a
// saturating arrival counter.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   det        : raw asynchronous detector level (1 = vehicle over loop)
//   clear      : zero the arrival counter on this edge (window boundary)
//   arrival    : high in the cycle whose edge accepts a filtered 0->1 change
//   count      : arrivals counted since the last clear, saturating
// ---------------------------------------------------------------------------
module det_channel #(
    parameter int unsigned DEBOUNCE_CYCLES = 8,
    parameter int unsigned CNT_W           = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             det,
    input  logic             clear,
    output logic             arrival,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned      STAB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic              s1;
    logic              s2;
    logic              level;
    logic [STAB_W-1:0] stab;
    logic              accept;

    // The stability counter holds the number of mismatching cycles already
    // seen; the edge that would make it DEBOUNCE_CYCLES accepts the change.
    assign accept  = (s2 != level) && (stab == STAB_LAST);
    assign arrival = accept && s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            level <= 1'b0;
            stab  <= '0;
            count <= '0;
        end else begin
            s1 <= det;
            s2 <= s1;

            if (s2 == level) begin
                stab <= '0;
            end else if (accept) begin
                level <= s2;
                stab  <= '0;
            end else begin
                stab <= stab + STAB_W'(1);
            end

            // An arrival coinciding with clear belongs to the closing window;
            // the top level folds it into that window's count.
            if (clear) begin
                count <= '0;
            end else if (arrival && (count != CNT_MAX)) begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/traffic_density_sensor.sv
// ---------------------------------------------------------------------------
// traffic_density_sensor
// Counts vehicle arrivals on four approaches over a fixed window and
// publishes a registered 2-bit density code per approach.
// Build option: define DENSITY_HYST_EN to add downward hysteresis on the
// published codes (a drop needs two consecutive lower windows).
// Ports:
//   clk, reset                       : clock, synchronous active-high reset
//   det_north/south/east/west        : raw asynchronous loop detectors
//   sensor_north/south/east/west     : registered density codes
//   sample_valid                     : one-cycle pulse, high in the first cycle
//                                      the new codes are visible
// sample_valid is a pure strobe: no ready, the consumer must take the codes
// while it is high or read the held codes any time before the next strobe.
// ---------------------------------------------------------------------------
module traffic_density_sensor
    import traffic_pkg::*;
#(
    parameter int unsigned WINDOW_CYCLES   = 1000,
    parameter int unsigned DEBOUNCE_CYCLES = 8,
    parameter int unsigned CNT_W           = 8,
    parameter int unsigned TH_LOW          = 3,
    parameter int unsigned TH_MED          = 6,
    parameter int unsigned TH_HIGH         = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       det_north,
    input  logic       det_south,
    input  logic       det_east,
    input  logic       det_west,
    output logic [1:0] sensor_north,
    output logic [1:0] sensor_south,
    output logic [1:0] sensor_east,
    output logic [1:0] sensor_west,
    output logic       sample_valid
);

    localparam int unsigned      WIN_W    = $clog2(WINDOW_CYCLES);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [WIN_W-1:0] win_cnt;
    logic             win_end;
    logic [3:0]       det_raw;
    logic [3:0]       arrival;
    logic [CNT_W-1:0] count     [4];
    logic [CNT_W-1:0] count_eff [4];
    logic [1:0]       cls       [4];
    logic [1:0]       next_code [4];
    logic [1:0]       code      [4];

    assign det_raw = {det_west, det_east, det_south, det_north};
    assign win_end = (win_cnt == WIN_LAST);

    for (genvar g = 0; g < 4; g++) begin : g_ch
        det_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .det     (det_raw[g]),
            .clear   (win_end),
            .arrival (arrival[g]),
            .count   (count[g])
        );
    end

    // Classify with any arrival on this same edge included, saturating.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            count_eff[i] = count[i];
            if (arrival[i] && (count[i] != CNT_MAX)) begin
                count_eff[i] = count[i] + CNT_W'(1);
            end
            cls[i] = classify_density(32'(count_eff[i]), TH_LOW, TH_MED, TH_HIGH);
        end
    end

`ifdef DENSITY_HYST_EN
    // Classification of the previous window, per approach.
    logic [1:0] hist [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            next_code[i] = code[i];
            if (cls[i] >= code[i]) begin
                next_code[i] = cls[i];
            end else if (hist[i] < code[i]) begin
                // Two windows in a row below the output: settle on the higher.
                next_code[i] = (cls[i] > hist[i]) ? cls[i] : hist[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) hist[i] <= DENS_NONE;
        end else if (win_end) begin
            for (int i = 0; i < 4; i++) hist[i] <= cls[i];
        end
    end
`else
    always_comb begin
        for (int i = 0; i < 4; i++) next_code[i] = cls[i];
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            win_cnt      <= '0;
            sample_valid <= 1'b0;
            for (int i = 0; i < 4; i++) code[i] <= DENS_NONE;
        end else begin
            sample_valid <= win_end;
            if (win_end) begin
                win_cnt <= '0;
                for (int i = 0; i < 4; i++) code[i] <= next_code[i];
            end else begin
                win_cnt <= win_cnt + WIN_W'(1);
            end
        end
    end

    assign sensor_north = code[0];
    assign sensor_south = code[1];
    assign sensor_east  = code[2];
    assign sensor_west  = code[3];

endmodule

// File: tb/tb_traffic_density_sensor.sv
// ---------------------------------------------------------------------------
// tb_traffic_density_sensor
// Directed and random detector pulses on a main instance (window 100) and a
// 4-bit-counter instance (window 400, west lane only). The reference model
// works on whole pulses: a high of at least DEB cycles is one arrival, landing
// DEB+2 edges after the edge it was driven behind; arrivals are binned per
// window and each window's bin is classified at its boundary.
// Build option DENSITY_HYST_EN selects the hysteresis rule in the model.
// ---------------------------------------------------------------------------
module tb_traffic_density_sensor;

  localparam int W     = 100;
  localparam int W_SAT = 400;
  localparam int DEB   = 4;
  localparam int TH_L  = 3;
  localparam int TH_M  = 6;
  localparam int TH_H  = 10;
  localparam int LANES = 5;   // 0..3 main N/S/E/W, 4 = saturation instance west
  localparam int NWIN  = 64;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b1;
  logic [LANES-1:0] det = '0;

  logic [1:0] s_n, s_s, s_e, s_w;
  logic       sv;
  logic [1:0] sat_n, sat_s, sat_e, sat_w;
  logic       sat_sv;

  traffic_density_sensor #(
    .WINDOW_CYCLES(W), .DEBOUNCE_CYCLES(DEB), .CNT_W(8),
    .TH_LOW(TH_L), .TH_MED(TH_M), .TH_HIGH(TH_H)
  ) dut (
    .clk(clk), .reset(reset),
    .det_north(det[0]), .det_south(det[1]), .det_east(det[2]), .det_west(det[3]),
    .sensor_north(s_n), .sensor_south(s_s), .sensor_east(s_e), .sensor_west(s_w),
    .sample_valid(sv)
  );

  traffic_density_sensor #(
    .WINDOW_CYCLES(W_SAT), .DEBOUNCE_CYCLES(DEB), .CNT_W(4),
    .TH_LOW(TH_L), .TH_MED(TH_M), .TH_HIGH(TH_H)
  ) dut_sat (
    .clk(clk), .reset(reset),
    .det_north(1'b0), .det_south(1'b0), .det_east(1'b0), .det_west(det[4]),
    .sensor_north(sat_n), .sensor_south(sat_s), .sensor_east(sat_e), .sensor_west(sat_w),
    .sample_valid(sat_sv)
  );

  // scoreboard / model state
  int         n_assert;
  int         n_fail;
  int         edge_n;
  int         cnt      [LANES][NWIN];
  logic [1:0] exp_out  [LANES];
  logic [1:0] prev_cls [LANES];
  int         seg_q    [LANES][$];   // span*2 + level
  int         rem      [LANES];

  function automatic logic [1:0] classify(int c);
    if (c < TH_L) return 2'b00;
    if (c < TH_M) return 2'b01;
    if (c < TH_H) return 2'b10;
    return 2'b11;
  endfunction

  task automatic check(string tag, logic [1:0] obs, logic [1:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s at edge %0d: observed %0d expected %0d", tag, edge_n, obs, expv);
    end
  endtask

  task automatic close_window(int l, int win);
    int c;
    logic [1:0] cl;
    c = cnt[l][win];
    if (l == 4 && c > 15) c = 15;
    cl = classify(c);
`ifdef DENSITY_HYST_EN
    if (cl >= exp_out[l]) exp_out[l] = cl;
    else if (prev_cls[l] < exp_out[l]) exp_out[l] = (cl > prev_cls[l]) ? cl : prev_cls[l];
`else
    exp_out[l] = cl;
`endif
    prev_cls[l] = cl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
    if (edge_n % W == 0) begin
      for (int l = 0; l < 4; l++) close_window(l, edge_n / W - 1);
    end
    if (edge_n % W_SAT == 0) close_window(4, edge_n / W_SAT - 1);
    check("sample_valid", {1'b0, sv}, (edge_n % W == 0) ? 2'd1 : 2'd0);
    check("sensor_north", s_n, exp_out[0]);
    check("sensor_south", s_s, exp_out[1]);
    check("sensor_east",  s_e, exp_out[2]);
    check("sensor_west",  s_w, exp_out[3]);
    check("sat_sample_valid", {1'b0, sat_sv}, (edge_n % W_SAT == 0) ? 2'd1 : 2'd0);
    check("sat_sensor_west", sat_w, exp_out[4]);
    check("sat_idle_lanes", sat_n | sat_s | sat_e, 2'b00);
  endtask

  task automatic do_reset(int n);
    reset = 1'b1;
    det = '0;
    for (int l = 0; l < LANES; l++) begin
      seg_q[l].delete();
      rem[l] = 0;
    end
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check("reset_sensor_north", s_n, 2'b00);
      check("reset_sensor_south", s_s, 2'b00);
      check("reset_sensor_east",  s_e, 2'b00);
      check("reset_sensor_west",  s_w, 2'b00);
      check("reset_sample_valid", {1'b0, sv}, 2'd0);
      check("reset_sat_west", sat_w, 2'b00);
    end
    reset = 1'b0;
    edge_n = 0;
    for (int l = 0; l < LANES; l++) begin
      exp_out[l] = 2'b00;
      prev_cls[l] = 2'b00;
      for (int w = 0; w < NWIN; w++) cnt[l][w] = 0;
    end
  endtask

  // driver tasks
  task automatic push(int l, bit v, int span);
    seg_q[l].push_back(span * 2 + int'(v));
  endtask

  task automatic pulses(int l, int n, int hi, int lo);
    for (int i = 0; i < n; i++) begin
      push(l, 1'b1, hi);
      push(l, 1'b0, lo);
    end
  endtask

  task automatic run_until(int target);
    int s;
    int ae;
    while (edge_n < target) begin
      for (int l = 0; l < LANES; l++) begin
        if (rem[l] == 0) begin
          if (seg_q[l].size() > 0) begin
            s = seg_q[l].pop_front();
            det[l] = s[0];
            rem[l] = s >>> 1;
            if (s[0] && rem[l] >= DEB) begin
              ae = edge_n + 2 + DEB;
              cnt[l][(ae - 1) / ((l == 4) ? W_SAT : W)]++;
            end
          end else begin
            det[l] = 1'b0;
            rem[l] = 1;
          end
        end
        rem[l]--;
      end
      tick();
    end
  endtask

  initial begin
    int total;
    int hi;
    int lo;
    n_assert = 0;
    n_fail = 0;
    edge_n = 0;

    // reset, idle main windows; saturation instance gets 20 arrivals meanwhile
    do_reset(5);
    pulses(4, 20, 5, 5);
    run_until(196);

    // 7 clean north pulses inside window 201..300; 3-cycle glitches on east
    pulses(0, 7, 8, 8);
    pulses(2, 20, 3, 3);
    run_until(400);

    // south: 12, 2, 2 arrivals in windows ending 500/600/700, one on edge 600
    pulses(1, 12, 4, 4);
    push(1, 1'b0, 44); pulses(1, 1, 4, 4);
    push(1, 1'b0, 46); pulses(1, 1, 4, 4);
    push(1, 1'b0, 18); pulses(1, 1, 4, 4);
    push(1, 1'b0, 20); pulses(1, 1, 4, 4);
    // west: 3 arrivals in window ending 600, the third on the terminal edge
    push(3, 1'b0, 120); pulses(3, 1, 4, 4);
    push(3, 1'b0, 32);  pulses(3, 1, 4, 4);
    push(3, 1'b0, 26);  pulses(3, 1, 4, 4);
    run_until(700);

    // random clean pulses on all four approaches at once
    for (int l = 0; l < 4; l++) begin
      total = 0;
      while (total < 700) begin
        hi = $urandom_range(1, 9);
        lo = $urandom_range(DEB, 9);
        push(l, 1'b1, hi);
        push(l, 1'b0, lo);
        total += hi + lo;
      end
    end
    run_until(1500);

    // east to medium, then 5 north arrivals and a reset 60 cycles into a window
    pulses(2, 8, 4, 4);
    run_until(1600);
    pulses(0, 5, 6, 6);
    run_until(1660);
    do_reset(3);
    run_until(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
